// File: rtl/bus_slave_resp_arb_pkg.sv
// Shared bus definitions: strobe levels, word width and the response FSM state encoding.
package bus_slave_resp_arb_pkg;

   localparam int unsigned WORD_DATA_W = 32;
   localparam int unsigned WAIT_CNT_W  = 16;

   // Bus strobes are active low
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StWait = 1'b1
   } bus_state_e;

endpackage

// File: rtl/bus_prio_enc.sv
// Priority encoder: index of the lowest-numbered asserted request bit.
module bus_prio_enc #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      idx   = '0;
      valid = |req;
      // Scan downwards so the lowest set bit is the last one written
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bus_slave_resp_arb.sv
// Slave response arbiter: latches the selected slave on a master strobe, then forwards its
// ready/data to the master as a one-cycle registered pulse, or an error on miss/timeout.
module bus_slave_resp_arb
   import bus_slave_resp_arb_pkg::*;
#(
   parameter int unsigned SLAVE_N = 8,
   parameter int unsigned DATA_W  = WORD_DATA_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mAs_,
   input  logic [SLAVE_N-1:0]        sCS_,
   input  logic [SLAVE_N*DATA_W-1:0] sRdData,
   input  logic [SLAVE_N-1:0]        sRdy_,
   output logic [DATA_W-1:0]         mRdData,
   output logic                      mRdy_,
   output logic                      mErr,
   output logic                      busy
);

   localparam int unsigned IDX_W = (SLAVE_N > 1) ? $clog2(SLAVE_N) : 1;
   localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

   bus_state_e             state_q;
   logic [IDX_W-1:0]       sel_q;
   logic [WAIT_CNT_W-1:0]  cnt_q;

   logic [SLAVE_N-1:0]     cs_req;
   logic [IDX_W-1:0]       enc_idx;
   logic                   enc_valid;
   logic                   sel_rdy;
   logic [DATA_W-1:0]      sel_data;

   assign cs_req = ~sCS_;

   bus_prio_enc #(
      .N     (SLAVE_N),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req   (cs_req),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // Only the latched slave is observed while waiting
   always_comb begin
      sel_rdy  = 1'b0;
      sel_data = '0;
      for (int i = 0; i < SLAVE_N; i++) begin
         if (sel_q == IDX_W'(i)) begin
            sel_rdy  = (sRdy_[i] == ENABLE_);
            sel_data = sRdData[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         sel_q   <= '0;
         cnt_q   <= '0;
         mRdy_   <= DISABLE_;
         mErr    <= 1'b0;
         mRdData <= '0;
      end else begin
         mRdy_   <= DISABLE_;
         mErr    <= 1'b0;
         mRdData <= '0;
         case (state_q)
            StIdle: begin
               if (mAs_ == ENABLE_) begin
                  if (enc_valid) begin
                     sel_q   <= enc_idx;
                     cnt_q   <= '0;
                     state_q <= StWait;
                  end else begin
                     mRdy_ <= ENABLE_;
                     mErr  <= 1'b1;
                  end
               end
            end
            StWait: begin
               // Ready takes precedence over an expiring wait counter
               if (sel_rdy) begin
                  mRdy_   <= ENABLE_;
                  mRdData <= sel_data;
                  state_q <= StIdle;
               end else if (cnt_q == CNT_LAST) begin
                  mRdy_   <= ENABLE_;
                  mErr    <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = (state_q == StWait);

endmodule

// File: tb/tb_bus_slave_resp_arb.sv
// Bench for bus_slave_resp_arb: directed scenarios plus random traffic against a
// transaction-level model; expected responses are queued and matched by a monitor.
module tb_bus_slave_resp_arb;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int TO = 4;
   localparam logic [N-1:0] H = '1;

   logic             clk = 1'b0;
   logic             reset;
   logic             mAs_;
   logic [N-1:0]     sCS_;
   logic [N*W-1:0]   sRdData;
   logic [N-1:0]     sRdy_;
   logic [W-1:0]     mRdData;
   logic             mRdy_;
   logic             mErr;
   logic             busy;

   bus_slave_resp_arb #(
      .SLAVE_N (N),
      .DATA_W  (W),
      .TIMEOUT (TO)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .mAs_    (mAs_),
      .sCS_    (sCS_),
      .sRdData (sRdData),
      .sRdy_   (sRdy_),
      .mRdData (mRdData),
      .mRdy_   (mRdy_),
      .mErr    (mErr),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           due;
      logic         err;
      logic [W-1:0] data;
   } resp_t;

   resp_t exp_q[$];
   bit    busy_exp[int];
   int    total = 0;
   int    bad   = 0;

   // Transaction-level model state
   bit m_busy      = 1'b0;
   int m_sel       = 0;
   int m_first     = 0;
   bit m_resp_next = 1'b0;

   // Drive one cycle of inputs and apply the model to them; fsel >= 0 forces that slave's data.
   task automatic step(input logic rst, input logic as_n, input logic [N-1:0] cs,
                       input logic [N-1:0] rdy, input int fsel, input logic [W-1:0] fdata);
      int lo;
      @(posedge clk);
      #2;
      reset = rst;
      mAs_  = as_n;
      sCS_  = cs;
      sRdy_ = rdy;
      for (int i = 0; i < N; i++) sRdData[i*W +: W] = $urandom;
      if (fsel >= 0) sRdData[fsel*W +: W] = fdata;
      m_resp_next = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (!as_n) begin
            lo = -1;
            for (int i = N - 1; i >= 0; i--) if (!cs[i]) lo = i;
            if (lo < 0) begin
               exp_q.push_back('{due: cyc + 1, err: 1'b1, data: '0});
               m_resp_next = 1'b1;
            end else begin
               m_busy  = 1'b1;
               m_sel   = lo;
               m_first = cyc + 1;
            end
         end
      end else if (!rdy[m_sel]) begin
         exp_q.push_back('{due: cyc + 1, err: 1'b0, data: sRdData[m_sel*W +: W]});
         m_resp_next = 1'b1;
         m_busy      = 1'b0;
      end else if (cyc == m_first + TO - 1) begin
         exp_q.push_back('{due: cyc + 1, err: 1'b1, data: '0});
         m_resp_next = 1'b1;
         m_busy      = 1'b0;
      end
      busy_exp[cyc + 1] = m_busy;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, H, H, -1, '0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a response
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (mRdy_ !== 1'b0) begin
            total++;
            if (mRdy_ !== 1'b1 || mErr !== 1'b0 || mRdData !== '0) begin
               bad++;
               $display("FAIL idle_out cyc=%0d: got rdy=%b err=%b data=%h, want rdy=1 err=0 data=0",
                        cyc, mRdy_, mErr, mRdData);
            end
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               r = exp_q.pop_front();
               total++;
               bad++;
               $display("FAIL missing_resp cyc=%0d: got no pulse, want err=%b data=%h at cyc %0d",
                        cyc, r.err, r.data, r.due);
            end
         end else begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_resp cyc=%0d: got err=%b data=%h, want no pulse",
                        cyc, mErr, mRdData);
            end else begin
               r = exp_q.pop_front();
               if (r.due != cyc || mErr !== r.err || mRdData !== r.data) begin
                  bad++;
                  $display("FAIL resp cyc=%0d: got err=%b data=%h, want err=%b data=%h at cyc %0d",
                           cyc, mErr, mRdData, r.err, r.data, r.due);
               end
            end
         end
         if (busy_exp.exists(cyc)) begin
            total++;
            if (busy !== busy_exp[cyc]) begin
               bad++;
               $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, busy_exp[cyc]);
            end
         end
      end
   end

   initial begin
      logic         r_rst;
      logic         r_as;
      logic [N-1:0] r_cs;
      logic [N-1:0] r_rdy;
      reset   = 1'b1;
      mAs_    = 1'b1;
      sCS_    = H;
      sRdy_   = H;
      sRdData = '0;
      step(1'b1, 1'b1, H, H, -1, '0);
      step(1'b1, 1'b1, H, H, -1, '0);
      idle(2);

      // Ready after wait
      step(1'b0, 1'b0, 8'b1111_1011, H, -1, '0);
      idle(2);
      step(1'b0, 1'b1, H, 8'b1111_1011, 2, 32'hDEAD_BEEF);
      idle(2);

      // Priority: slave 3 wins, slave 5 ready is ignored, chip-select changes ignored
      step(1'b0, 1'b0, 8'b0101_0111, H, -1, '0);
      step(1'b0, 1'b1, 8'h00, 8'b1101_1111, -1, '0);
      step(1'b0, 1'b1, H, 8'b1111_0111, -1, '0);
      idle(2);

      // Timeout on slave 1
      step(1'b0, 1'b0, 8'b1111_1101, H, -1, '0);
      idle(6);

      // Decode miss
      step(1'b0, 1'b0, H, H, -1, '0);
      idle(2);

      // Ready coinciding with the last wait cycle
      step(1'b0, 1'b0, 8'b1011_1111, H, -1, '0);
      idle(3);
      step(1'b0, 1'b1, H, 8'b1011_1111, -1, '0);
      idle(2);

      // Reset in the second wait cycle, then a stale ready
      step(1'b0, 1'b0, 8'b1110_1111, H, -1, '0);
      step(1'b0, 1'b1, H, H, -1, '0);
      step(1'b1, 1'b1, H, 8'b1110_1111, -1, '0);
      step(1'b0, 1'b1, H, 8'b1110_1111, -1, '0);
      idle(3);

      for (int n = 0; n < 1500; n++) begin
         r_rst = ($urandom_range(0, 59) == 0);
         r_as  = ($urandom_range(0, 2) != 0);
         r_cs  = ($urandom_range(0, 4) == 0) ? H : N'($urandom);
         for (int i = 0; i < N; i++) r_rdy[i] = ($urandom_range(0, 4) != 0);
         // A miss strobed in a response cycle would need back-to-back pulses
         if (m_resp_next && r_cs == H) r_as = 1'b1;
         step(r_rst, r_as, r_cs, r_rdy, -1, '0);
      end
      idle(TO + 4);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d outstanding responses, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_slave_resp_arb.md
BUS_SLAVE_RESP_ARB -- requirements
Module: bus_slave_resp_arb

Interface
REQ-001 Parameter SLAVE_N, default 8: number of slave response channels, 1..16.
REQ-002 Parameter DATA_W, default 32: read-data width per slave.
REQ-003 Parameter TIMEOUT, default 255: wait cycles before the error response, 1..65535.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port mAs_, input, 1: master address strobe, active low; marks the cycle a transaction starts.
REQ-007 Port sCS_, input, SLAVE_N: per-slave chip select, active low; bit i belongs to slave i.
REQ-008 Port sRdData, input, SLAVE_N*DATA_W: packed slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Port sRdy_, input, SLAVE_N: per-slave ready, active low.
REQ-010 Port mRdData, output, DATA_W: registered read data to the master.
REQ-011 Port mRdy_, output, 1: registered ready to the master, active low, one-cycle pulse per transaction.
REQ-012 Port mErr, output, 1: registered error flag, valid only while mRdy_ is low.
REQ-013 Port busy, output, 1: high while a transaction is outstanding (state WAIT).

Function
REQ-014 The FSM SHALL have two states: IDLE and WAIT.
REQ-015 In IDLE with mAs_ low and at least one sCS_ bit low, the block SHALL latch the index of the lowest-numbered low sCS_ bit into selIdx and enter WAIT next cycle.
REQ-016 In IDLE with mAs_ low and all sCS_ high (decode miss), the next cycle SHALL be mRdy_=0, mErr=1, mRdData=0, and the FSM stays in IDLE.
REQ-017 In WAIT, responses SHALL come only from slave selIdx; sCS_ changes after latching SHALL be ignored.
REQ-018 In WAIT, when sRdy_[selIdx] is low, the next cycle SHALL be mRdy_=0, mErr=0, mRdData=slave selIdx data sampled in that cycle, and the FSM returns to IDLE.
REQ-019 A 16-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ready.
REQ-020 When the counter equals TIMEOUT-1 and ready is absent, the next cycle SHALL be mRdy_=0, mErr=1, mRdData=0, and the FSM returns to IDLE.
REQ-021 Ready and the timeout in the same cycle SHALL resolve to a normal response: ready wins, mErr=0.
REQ-022 mAs_ low during WAIT SHALL be ignored and not queued.
REQ-023 A response-cycle mAs_ SHALL be accepted: the IDLE transition of REQ-015/016 applies on the cycle mRdy_ is low.
REQ-024 Outside response cycles, mRdy_=1, mErr=0 and mRdData=0; mRdy_ SHALL never be low two cycles in a row.
REQ-025 Latency: a slave ready in cycle N gives master ready in cycle N+1; a decode miss strobed in cycle N gives error in cycle N+1.

Reset
REQ-026 reset high at a clock edge SHALL force IDLE, counter=0, selIdx=0, mRdy_=1, mErr=0, mRdData=0, busy=0, regardless of state.
REQ-027 A transaction interrupted by reset SHALL produce no response; a slave ready arriving after reset SHALL be ignored.

Structure
REQ-028 FSM state encodings and the ENABLE_/DISABLE_ levels SHALL come from the shared bus header; the width defaults SHALL match the shared WORD_DATA_W definition.
REQ-029 Lowest-index selection SHALL be one parametrised sub-module, bus_prio_enc (SLAVE_N-bit request in; index and any-valid out).

Verification
REQ-030 The bench SHALL cover each scenario below with SLAVE_N=8 and TIMEOUT=4.
- Scenario 1, ready after wait: sCS_=8'b1111_1011, mAs_ pulse, sRdy_[2] low 3 cycles later with data 32'hDEAD_BEEF -> one cycle later mRdy_=0, mErr=0, mRdData=32'hDEAD_BEEF; then IDLE.
- Scenario 2, priority: sCS_=8'b0101_0111 (slaves 3, 5 and 7 low) -> selIdx=3; a ready from slave 5 alone gives no response.
- Scenario 3, timeout: slave 1 selected, never ready -> mRdy_=0, mErr=1, mRdData=0 exactly 5 cycles after the strobe.
- Scenario 4, decode miss: sCS_=8'hFF with mAs_ low -> the next cycle gives mRdy_=0, mErr=1; busy stays 0.
- Scenario 5, tie: sRdy_[selIdx] low in the cycle the counter reaches 3 -> mErr=0 with slave data.
- Scenario 6, reset mid-op: reset in the 2nd WAIT cycle, then sRdy_ low -> no mRdy_ pulse; all outputs at reset values.
